adder_tree_pipe: RTL and testbench

//  Parametrised, fully pipelined signed adder tree for the symmetric FIR datapath: sums NUM_IN
//  tap products per sample, one register level per tree layer. Adds valid/ready flow control

---
 rtl/adder_tree_pipe.sv | 149 ++++++++++++++
 tb/tb_adder_tree_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree, one register per layer plus a round/saturate stage; latency $clog2(NUM_IN)+1.
// Backpressure: a single global enable (!out_valid | out_ready) stalls every stage; in_ready is that enable.
module adder_tree_pipe #(
    parameter int IN_W   = 42,
    parameter int NUM_IN = 51,
    parameter int OUT_W  = 48,
    parameter int SHIFT  = 0,
    parameter int SAT_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int FULL_W = IN_W + LEVELS;

    // Number of values held by tree layer k (layer 0 is the input vector).
    function automatic int lvl_n(input int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    // Bit offset of layer k inside the packed tree register (layers 1..LEVELS).
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 1; i < k; i++) begin
            o += lvl_n(i) * (IN_W + i);
        end
        return o;
    endfunction

    localparam int TREE_BITS = lvl_off(LEVELS + 1);
    localparam int FIN_OFF   = lvl_off(LEVELS);

    localparam logic [FULL_W:0]  RND     = {{FULL_W{1'b0}}, 1'b1} << SHIFT >> 1;
    localparam logic [OUT_W-1:0] SAT_MAX = {OUT_W{1'b1}} >> 1;
    localparam logic [OUT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                  en;
    logic [TREE_BITS-1:0]  tree_sum;
    logic [TREE_BITS-1:0]  tree_d;
    logic [TREE_BITS-1:0]  tree_q;
    logic [LEVELS:0]       vld_d;
    logic [LEVELS:0]       vld_q;
    logic [OUT_W-1:0]      out_dat_d;
    logic [OUT_W-1:0]      out_dat_q;
    logic                  out_sat_d;
    logic                  out_sat_q;

    logic [FULL_W-1:0]     fin_sum;
    logic signed [FULL_W:0] rnd_sum;
    logic signed [FULL_W:0] shifted;
    logic                  fits;

    assign en        = !vld_q[LEVELS] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[LEVELS];
    assign out_data  = out_dat_q;
    assign out_sat   = out_sat_q;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int W    = IN_W + k;
        localparam int NP   = lvl_n(k - 1);
        localparam int NK   = lvl_n(k);
        localparam int OFF  = lvl_off(k);
        localparam int POFF = lvl_off(k - 1);

        logic [NP*(W-1)-1:0] src;

        if (k == 1) begin : g_src_in
            assign src = in_data;
        end else begin : g_src_tree
            assign src = tree_q[POFF +: NP*(W-1)];
        end

        for (genvar j = 0; j < NK; j++) begin : g_node
            logic [W-2:0] a;
            assign a = src[2*j*(W-1) +: W-1];

            if (2*j + 1 < NP) begin : g_add
                logic [W-2:0] b;
                assign b = src[(2*j+1)*(W-1) +: W-1];
                assign tree_sum[OFF + j*W +: W] = {a[W-2], a} + {b[W-2], b};
            end else begin : g_pass
                // Odd leftover is registered too so every path has the same latency.
                assign tree_sum[OFF + j*W +: W] = {a[W-2], a};
            end
        end
    end

    always_comb begin
        tree_d = tree_q;
        if (en) begin
            tree_d = tree_sum;
        end
    end

    // Clear wins over stall so a flush always empties the pipe in one edge.
    always_comb begin
        vld_d = vld_q;
        if (clear) begin
            vld_d = '0;
        end else if (en) begin
            vld_d = {vld_q[LEVELS-1:0], in_valid};
        end
    end

    // One extra bit of headroom keeps the half-LSB rounding add from overflowing.
    assign fin_sum = tree_q[FIN_OFF +: FULL_W];
    assign rnd_sum = $signed({fin_sum[FULL_W-1], fin_sum} + RND);
    assign shifted = rnd_sum >>> SHIFT;
    assign fits    = (&shifted[FULL_W:OUT_W-1]) | ~(|shifted[FULL_W:OUT_W-1]);

    always_comb begin
        out_dat_d = out_dat_q;
        out_sat_d = out_sat_q;
        if (en) begin
            out_dat_d = shifted[OUT_W-1:0];
            out_sat_d = 1'b0;
            if ((SAT_EN != 0) && !fits) begin
                out_dat_d = shifted[FULL_W] ? SAT_MIN : SAT_MAX;
                out_sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q    <= '0;
            vld_q     <= '0;
            out_dat_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            tree_q    <= tree_d;
            vld_q     <= vld_d;
            out_dat_q <= out_dat_d;
            out_sat_q <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: default 51-input instance plus small rounding,
// wrap and odd-width instances.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clear;
    logic oth_rdy;
    int   checks   = 0;
    int   failures = 0;

    // Instance A: default parameters
    logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
    logic [51*42-1:0]   a_in_data;
    logic [47:0]        a_out_data;
    // Instances C/D: 4 inputs, 16-bit out, shift 4, saturate / wrap
    logic               c_in_valid, c_in_ready, c_out_valid, c_out_sat;
    logic               d_in_valid, d_in_ready, d_out_valid, d_out_sat;
    logic [127:0]       c_in_data, d_in_data;
    logic [15:0]        c_out_data, d_out_data;
    // Instances E/F: 2 and 3 inputs of 8 bits
    logic               e_in_valid, e_in_ready, e_out_valid, e_out_sat;
    logic               f_in_valid, f_in_ready, f_out_valid, f_out_sat;
    logic [15:0]        e_in_data;
    logic [23:0]        f_in_data;
    logic [8:0]         e_out_data;
    logic [9:0]         f_out_data;

    adder_tree_pipe #(.IN_W(42), .NUM_IN(51), .OUT_W(48), .SHIFT(0), .SAT_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_sat(a_out_sat));

    adder_tree_pipe #(.IN_W(32), .NUM_IN(4), .OUT_W(16), .SHIFT(4), .SAT_EN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(oth_rdy),
        .out_data(c_out_data), .out_sat(c_out_sat));

    adder_tree_pipe #(.IN_W(32), .NUM_IN(4), .OUT_W(16), .SHIFT(4), .SAT_EN(0)) u_d (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(oth_rdy),
        .out_data(d_out_data), .out_sat(d_out_sat));

    adder_tree_pipe #(.IN_W(8), .NUM_IN(2), .OUT_W(9), .SHIFT(0), .SAT_EN(1)) u_e (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(oth_rdy),
        .out_data(e_out_data), .out_sat(e_out_sat));

    adder_tree_pipe #(.IN_W(8), .NUM_IN(3), .OUT_W(10), .SHIFT(0), .SAT_EN(1)) u_f (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_data(f_in_data), .out_valid(f_out_valid), .out_ready(oth_rdy),
        .out_data(f_out_data), .out_sat(f_out_sat));

    typedef struct {
        logic [127:0] din;
        longint       c_dat;
        logic         c_sat;
        longint       d_dat;
    } vec_t;

    function automatic vec_t mk(input int v0, input int v1, input int v2, input int v3,
                                input longint cd, input logic cs, input longint dd);
        vec_t r;
        r.din   = {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
        r.c_dat = cd;
        r.c_sat = cs;
        r.d_dat = dd;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_a_all(input logic [41:0] v);
        for (int i = 0; i < 51; i++) a_in_data[i*42 +: 42] = v;
    endtask

    // Returns the number of edges (accepting edge included) until out_valid, or -1.
    task automatic wait_valid(input int which, output int lat);
        logic v;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            a_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
            e_in_valid = 1'b0; f_in_valid = 1'b0;
            case (which)
                0:       v = a_out_valid;
                1:       v = e_out_valid;
                default: v = f_out_valid;
            endcase
            if (v) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        rows[12];
        int          lat;
        int          sent, rcvd, spurious;
        longint      exp_q[$];
        longint      held, s;
        logic        hold_chk, en_exp;
        logic [41:0] e;

        rst_n = 1'b0; clear = 1'b0; oth_rdy = 1'b1;
        a_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0; e_in_valid = 1'b0; f_in_valid = 1'b0;
        a_in_data = '0; c_in_data = '0; d_in_data = '0; e_in_data = '0; f_in_data = '0;
        a_out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_a_valid", longint'(a_out_valid), 0);
        chk("rst_a_data",  longint'(a_out_data), 0);
        chk("rst_a_sat",   longint'(a_out_sat), 0);
        chk("rst_a_ready", longint'(a_in_ready), 1);
        chk("rst_cdef_valid", longint'({c_out_valid, d_out_valid, e_out_valid, f_out_valid}), 0);
        chk("rst_cdef_ready", longint'({c_in_ready, d_in_ready, e_in_ready, f_in_ready}), 15);
        chk("rst_ef_sat", longint'({e_out_sat, f_out_sat}), 0);
        rst_n = 1'b1;

        // 1: all +1
        @(negedge clk);
        set_a_all(42'd1); a_in_valid = 1'b1; a_out_ready = 1'b1;
        wait_valid(0, lat);
        chk("t1_latency", longint'(lat), 7);
        chk("t1_data", longint'($signed(a_out_data)), 51);
        chk("t1_sat", longint'(a_out_sat), 0);
        @(negedge clk);
        chk("t1_single_output", longint'(a_out_valid), 0);

        // 2: all most-negative
        set_a_all(42'h200_0000_0000); a_in_valid = 1'b1;
        wait_valid(0, lat);
        chk("t2_latency", longint'(lat), 7);
        chk("t2_data", longint'($signed(a_out_data)), -51 * (longint'(1) << 41));
        chk("t2_sat", longint'(a_out_sat), 0);
        @(negedge clk);
        chk("t2_single_output", longint'(a_out_valid), 0);

        // 3: random stream with random backpressure
        sent = 0; rcvd = 0; hold_chk = 1'b0; held = 0; s = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
            if (hold_chk) begin
                chk("t3_hold_valid", longint'(a_out_valid), 1);
                chk("t3_hold_data", longint'($signed(a_out_data)), held);
            end
            a_out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                s = 0;
                for (int i = 0; i < 51; i++) begin
                    e = 42'({$urandom(), $urandom()});
                    a_in_data[i*42 +: 42] = e;
                    s += longint'($signed(e));
                end
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            en_exp = !a_out_valid || a_out_ready;
            chk("t3_in_ready", longint'(a_in_ready), longint'(en_exp));
            hold_chk = a_out_valid && !a_out_ready;
            held = longint'($signed(a_out_data));
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) chk("t3_queue_nonempty", longint'(exp_q.size()), 1);
                else chk("t3_data", longint'($signed(a_out_data)), exp_q.pop_front());
                rcvd++;
            end
            if (a_in_valid && en_exp) begin
                exp_q.push_back(s);
                sent++;
            end
            @(negedge clk);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("t3_sent", longint'(sent), 20);
        chk("t3_received", longint'(rcvd), 20);
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_out_valid) spurious++;
        end
        chk("t3_no_extra_output", longint'(spurious), 0);

        // 4: rounding, saturation and wrap, streamed back to back
        rows[0]  = mk(24, 0, 0, 0, 2, 1'b0, 2);
        rows[1]  = mk(1 << 30, 0, 0, 0, 32767, 1'b1, 0);
        rows[2]  = mk(-(1 << 30), 0, 0, 0, -32768, 1'b1, 0);
        rows[3]  = mk(-24, 0, 0, 0, -1, 1'b0, -1);
        rows[4]  = mk(-25, 0, 0, 0, -2, 1'b0, -2);
        rows[5]  = mk(-8, 0, 0, 0, 0, 1'b0, 0);
        rows[6]  = mk(23, 0, 0, 0, 1, 1'b0, 1);
        rows[7]  = mk(524272, 0, 0, 0, 32767, 1'b0, 32767);
        rows[8]  = mk(524280, 0, 0, 0, 32767, 1'b1, -32768);
        rows[9]  = mk(1000000, 2000000, 0, 7, 32767, 1'b1, -9108);
        rows[10] = mk(32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, -32768, 1'b1, 0);
        rows[11] = mk(100000, 200000, -50000, 3, 15625, 1'b0, 15625);
        for (int i = 0; i < 15; i++) begin
            if (i >= 3) begin
                chk($sformatf("t4_valid_%0d", i - 3), longint'({c_out_valid, d_out_valid}), 3);
                chk($sformatf("t4_sat_data_%0d", i - 3), longint'($signed(c_out_data)), rows[i-3].c_dat);
                chk($sformatf("t4_sat_flag_%0d", i - 3), longint'(c_out_sat), longint'(rows[i-3].c_sat));
                chk($sformatf("t4_wrap_data_%0d", i - 3), longint'($signed(d_out_data)), rows[i-3].d_dat);
                chk($sformatf("t4_wrap_flag_%0d", i - 3), longint'(d_out_sat), 0);
            end
            if (i < 12) begin
                c_in_data = rows[i].din; d_in_data = rows[i].din;
                c_in_valid = 1'b1; d_in_valid = 1'b1;
            end else begin
                c_in_valid = 1'b0; d_in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // 5a: flush with samples in flight
        for (int k = 1; k <= 7; k++) begin
            set_a_all(42'(k)); a_in_valid = 1'b1;
            @(negedge clk);
        end
        chk("t5_pre_valid", longint'(a_out_valid), 1);
        chk("t5_pre_data", longint'($signed(a_out_data)), 51);
        clear = 1'b1; set_a_all(42'd9); a_in_valid = 1'b1;
        #1;
        chk("t5_in_ready_during_clear", longint'(a_in_ready), 1);
        @(negedge clk);
        clear = 1'b0; a_in_valid = 1'b0;
        chk("t5_clear_valid", longint'(a_out_valid), 0);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_out_valid) spurious++;
        end
        chk("t5_no_stale_after_clear", longint'(spurious), 0);
        set_a_all(42'd2); a_in_valid = 1'b1;
        wait_valid(0, lat);
        chk("t5_clear_relatency", longint'(lat), 7);
        chk("t5_clear_data", longint'($signed(a_out_data)), 102);

        // 5b: asynchronous reset pulse mid-stream
        for (int k = 0; k < 4; k++) begin
            set_a_all(42'd3); a_in_valid = 1'b1;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("t5_rst_valid", longint'(a_out_valid), 0);
        chk("t5_rst_data", longint'(a_out_data), 0);
        chk("t5_rst_sat", longint'(a_out_sat), 0);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_out_valid) spurious++;
        end
        chk("t5_no_stale_after_reset", longint'(spurious), 0);
        set_a_all(42'h3FF_FFFF_FFFF); a_in_valid = 1'b1;
        wait_valid(0, lat);
        chk("t5_rst_relatency", longint'(lat), 7);
        chk("t5_rst_data_after", longint'($signed(a_out_data)), -51);

        // 6: two- and three-input trees
        e_in_data = {8'hFF, 8'hFF}; e_in_valid = 1'b1;
        wait_valid(1, lat);
        chk("t6_n2_latency", longint'(lat), 2);
        chk("t6_n2_data", longint'($signed(e_out_data)), -2);
        e_in_data = {8'h80, 8'h80}; e_in_valid = 1'b1;
        wait_valid(1, lat);
        chk("t6_n2_min_latency", longint'(lat), 2);
        chk("t6_n2_min_data", longint'($signed(e_out_data)), -256);
        chk("t6_n2_min_sat", longint'(e_out_sat), 0);
        f_in_data = {8'hFF, 8'hFF, 8'hFF}; f_in_valid = 1'b1;
        wait_valid(2, lat);
        chk("t6_n3_latency", longint'(lat), 3);
        chk("t6_n3_data", longint'($signed(f_out_data)), -3);
        f_in_data = {8'h7F, 8'h7F, 8'h7F}; f_in_valid = 1'b1;
        wait_valid(2, lat);
        chk("t6_n3_max_latency", longint'(lat), 3);
        chk("t6_n3_max_data", longint'($signed(f_out_data)), 381);
        chk("t6_n3_max_sat", longint'(f_out_sat), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
